// File: rtl/pmem_responder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pmem_responder
//
// Slave end of the core's load/store path. Accepts one read or write request
// at a time over a valid/ready channel and services it from an internal word
// array after an access latency. It then returns data and status on a
// valid/ready response channel.
//
// Optional feature macro: PMEM_RESP_RAND_LAT_EN
//   When defined, the access latency is taken from a free-running 16-bit LFSR
//   at the accept edge instead of the LATENCY parameter.
//
// Parameters:
//   DEPTH_WORDS : number of 32-bit words backed (power of two)
//   BASE_ADDR   : byte address of word 0
//   LATENCY     : wait cycles between accept and response (0..15)
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req_valid / req_ready : request handshake (req_ready high only in IDLE)
//   req_wen               : 1 = write, 0 = read
//   req_addr              : byte address, bits [1:0] ignored
//   req_wdata / req_wmask : write data and byte-lane enables
//   resp_valid/resp_ready : response handshake
//   resp_rdata            : read data (0 for writes and errors)
//   resp_err              : request address was out of range
// ---------------------------------------------------------------------------
module pmem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAT4  = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_next_s;
  logic [3:0]  eff_lat_s;
  logic        accept_s;
  logic        do_access_s;

  // Request fields captured at the accept edge
  logic        wen_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [3:0]  wmask_r;

  // Fields used by the access: live request when accessing straight from
  // IDLE (zero latency), captured copy otherwise
  logic        acc_wen_s;
  logic [31:0] acc_addr_s;
  logic [31:0] acc_wdata_s;
  logic [3:0]  acc_wmask_s;

  logic [30:0]      word_diff_s;
  logic [29:0]      word_off_s;
  logic             borrow_s;
  logic             in_range_s;
  logic [IDX_W-1:0] idx_s;
  logic             mem_we_s;
  logic             unused_addr_lsbs;

  logic [31:0] mem [DEPTH_WORDS];

`ifdef PMEM_RESP_RAND_LAT_EN
  logic [15:0] lfsr_r;

  // Fibonacci LFSR, taps 16,14,13,11, advancing every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r <= 16'hACE1;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    end
  end

  assign eff_lat_s = lfsr_r[3:0];
`else
  assign eff_lat_s = LAT4;
`endif

  assign req_ready = (state_r == IDLE);

  // Select which copy of the request fields drives the access
  always_comb begin
    acc_wen_s   = wen_r;
    acc_addr_s  = addr_r;
    acc_wdata_s = wdata_r;
    acc_wmask_s = wmask_r;
    if (state_r == IDLE) begin
      acc_wen_s   = req_wen;
      acc_addr_s  = req_addr;
      acc_wdata_s = req_wdata;
      acc_wmask_s = req_wmask;
    end else begin
      acc_wen_s   = wen_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
      acc_wmask_s = wmask_r;
    end
  end

  // Word-granular subtraction; the extra top bit is the borrow, which flags
  // addresses below BASE_ADDR
  assign word_diff_s      = {1'b0, acc_addr_s[31:2]} - {1'b0, BASE_ADDR[31:2]};
  assign borrow_s         = word_diff_s[30];
  assign word_off_s       = word_diff_s[29:0];
  assign in_range_s       = !borrow_s && ({2'b00, word_off_s} < 32'(DEPTH_WORDS));
  assign idx_s            = word_off_s[IDX_W-1:0];
  assign unused_addr_lsbs = ^acc_addr_s[1:0];

  // Next-state, counter and access-strobe decode
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    do_access_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          if (eff_lat_s != 4'd0) begin
            cnt_next_s   = eff_lat_s;
            state_next_s = WAIT;
          end else begin
            cnt_next_s   = 4'd0;
            do_access_s  = 1'b1;
            state_next_s = RESP;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        cnt_next_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          do_access_s  = 1'b1;
          state_next_s = RESP;
        end else begin
          state_next_s = WAIT;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // State, counter, captured request and registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      wen_r      <= 1'b0;
      addr_r     <= 32'h0;
      wdata_r    <= 32'h0;
      wmask_r    <= 4'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      if (accept_s) begin
        wen_r   <= req_wen;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
        wmask_r <= req_wmask;
      end
      if (do_access_s) begin
        resp_valid <= 1'b1;
        resp_err   <= !in_range_s;
        resp_rdata <= (!acc_wen_s && in_range_s) ? mem[idx_s] : 32'h0;
      end else if ((state_r == RESP) && resp_ready) begin
        resp_valid <= 1'b0;
        resp_rdata <= 32'h0;
        resp_err   <= 1'b0;
      end
    end
  end

  // Reset suppresses the write so an aborted transaction never lands
  assign mem_we_s = do_access_s && acc_wen_s && in_range_s && !reset;

  // Byte-lane write into the backing array (contents are not reset)
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wmask_s[b]) begin
          mem[idx_s][8*b +: 8] <= acc_wdata_s[8*b +: 8];
        end
      end
    end
  end

endmodule
